// File: rtl/second_game_controller_if.sv
// Bus between the game controller and its surroundings: buttons, the pixel
// scan, the ball position from the engine, and the controller's status outputs.
interface second_game_controller_if;
  logic       i_start_btn;
  logic       i_pause_btn;
  logic       i_frame_start;
  logic       i_pixel_valid;
  logic [8:0] i_screen_x;
  logic [9:0] i_screen_y;
  logic       i_is_obstacle;
  logic [8:0] i_ball_x;
  logic [9:0] i_ball_y;

  logic        o_engine_arst_n;
  logic        o_is_pause;
  logic        o_is_lose;
  logic [15:0] o_score;
  logic [1:0]  o_lives;
  logic [2:0]  o_state;

  modport master (
    output i_start_btn, i_pause_btn, i_frame_start, i_pixel_valid,
           i_screen_x, i_screen_y, i_is_obstacle, i_ball_x, i_ball_y,
    input  o_engine_arst_n, o_is_pause, o_is_lose, o_score, o_lives, o_state
  );

  modport slave (
    input  i_start_btn, i_pause_btn, i_frame_start, i_pixel_valid,
           i_screen_x, i_screen_y, i_is_obstacle, i_ball_x, i_ball_y,
    output o_engine_arst_n, o_is_pause, o_is_lose, o_score, o_lives, o_state
  );
endinterface

// File: rtl/second_game_controller.sv
// Game flow controller: start/countdown/run/hit-grace/pause/lose sequencing,
// per-frame collision accumulation, score and lives bookkeeping.
module second_game_controller #(
  parameter int PLAYER_SIZE      = 30,
  parameter int LIVES            = 3,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int GRACE_FRAMES     = 60
) (
  input logic                     clk,
  input logic                     rst,
  second_game_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_HIT       = 3'd3,
    S_PAUSED    = 3'd4,
    S_LOSE      = 3'd5
  } state_e;

  localparam logic [10:0] BOX_M1     = 11'(PLAYER_SIZE - 1);
  localparam logic [15:0] CD_LAST    = 16'(COUNTDOWN_FRAMES - 1);
  localparam logic [15:0] GRACE_INIT = 16'(GRACE_FRAMES);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [15:0] cd_q, cd_d;
  logic [15:0] grace_q, grace_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        hit_acc_q, hit_acc_d;
  logic        arst_n_q, arst_n_d;
  logic        start_prev_q, pause_prev_q;
  logic        is_pause_q, is_lose_q;

  logic        start_press, pause_press, pixel_hit;
  logic [10:0] px, py, bx, by;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Edge-detect buttons and test the current pixel against the ball box in 11 bits
  always_comb begin
    start_press = bus.i_start_btn & ~start_prev_q;
    pause_press = bus.i_pause_btn & ~pause_prev_q;
    px = {2'b00, bus.i_screen_x};
    py = {1'b0, bus.i_screen_y};
    bx = {2'b00, bus.i_ball_x};
    by = {1'b0, bus.i_ball_y};
    pixel_hit = bus.i_pixel_valid & bus.i_is_obstacle &
                (px >= bx) & (px <= bx + BOX_M1) &
                (py >= by) & (py <= by + BOX_M1);
  end

  // Next-state and datapath updates; frame evaluation sees last frame's hit_acc
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cd_d      = cd_q;
    grace_d   = grace_q;
    score_d   = score_q;
    lives_d   = lives_q;
    arst_n_d  = 1'b1;
    // A hit in the frame-start cycle already belongs to the new frame.
    hit_acc_d = bus.i_frame_start ? pixel_hit : (hit_acc_q | pixel_hit);

    unique case (state_q)
      S_IDLE, S_LOSE: begin
        if (start_press) begin
          state_d  = S_COUNTDOWN;
          arst_n_d = 1'b0;
          lives_d  = LIVES_INIT;
          score_d  = '0;
          cd_d     = '0;
        end
      end
      S_COUNTDOWN: begin
        if (bus.i_frame_start) begin
          if (cd_q == CD_LAST) begin
            state_d = S_RUN;
            cd_d    = '0;
          end else begin
            cd_d = cd_q + 16'd1;
          end
        end
      end
      S_RUN, S_HIT: begin
        // Pause wins over a coincident frame start: that frame is dropped.
        if (pause_press) begin
          ret_d   = state_q;
          state_d = S_PAUSED;
        end else if (bus.i_frame_start) begin
          score_d = sat_inc16(score_q);
          if (state_q == S_RUN) begin
            if (hit_acc_q) begin
              lives_d = lives_q - 2'd1;
              if (lives_q == 2'd1) begin
                state_d = S_LOSE;
              end else begin
                state_d = S_HIT;
                grace_d = GRACE_INIT;
              end
            end
          end else begin
            if (grace_q <= 16'd1) begin
              state_d = S_RUN;
              grace_d = '0;
            end else begin
              grace_d = grace_q - 16'd1;
            end
          end
        end
      end
      S_PAUSED: begin
        if (pause_press) state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset dominates every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ret_q        <= S_RUN;
      cd_q         <= '0;
      grace_q      <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      hit_acc_q    <= 1'b0;
      arst_n_q     <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      is_pause_q   <= 1'b1;
      is_lose_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cd_q         <= cd_d;
      grace_q      <= grace_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      hit_acc_q    <= hit_acc_d;
      arst_n_q     <= arst_n_d;
      start_prev_q <= bus.i_start_btn;
      pause_prev_q <= bus.i_pause_btn;
      is_pause_q   <= ~((state_d == S_RUN) || (state_d == S_HIT));
      is_lose_q    <= (state_d == S_LOSE);
    end
  end

  assign bus.o_engine_arst_n = arst_n_q;
  assign bus.o_is_pause      = is_pause_q;
  assign bus.o_is_lose       = is_lose_q;
  assign bus.o_score         = score_q;
  assign bus.o_lives         = lives_q;
  assign bus.o_state         = state_q;

endmodule

// File: tb/tb_second_game_controller.sv
// Testbench for second_game_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a rule-level reference model.
module tb_second_game_controller;
  localparam int PS  = 30;
  localparam int LV  = 3;
  localparam int CDF = 180;
  localparam int GF  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  second_game_controller_if bus();

  second_game_controller #(
    .PLAYER_SIZE(PS), .LIVES(LV), .COUNTDOWN_FRAMES(CDF), .GRACE_FRAMES(GF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: game state as plain integers (0 idle,1 countdown,2 run,3 hit,4 paused,5 lose)
  int m_state = 0, m_ret = 2, m_lives = LV, m_score = 0, m_frames = 0, m_grace = 0;
  bit m_frame_hit = 0, m_sprev = 0, m_pprev = 0, m_arst = 0;

  function automatic void model_step();
    bit sp, pp, ph;
    int px, py, bx, by;
    px = int'(bus.i_screen_x);
    py = int'(bus.i_screen_y);
    bx = int'(bus.i_ball_x);
    by = int'(bus.i_ball_y);
    ph = bus.i_pixel_valid && bus.i_is_obstacle &&
         px >= bx && px < bx + PS && py >= by && py < by + PS;
    if (rst) begin
      m_state = 0; m_ret = 2; m_lives = LV; m_score = 0; m_frames = 0; m_grace = 0;
      m_frame_hit = 0; m_sprev = 0; m_pprev = 0; m_arst = 0;
      return;
    end
    sp = bus.i_start_btn && !m_sprev;
    pp = bus.i_pause_btn && !m_pprev;
    m_arst = 1;
    if (m_state == 0 || m_state == 5) begin
      if (sp) begin
        m_state = 1; m_arst = 0; m_lives = LV; m_score = 0; m_frames = 0;
      end
    end else if (m_state == 1) begin
      if (bus.i_frame_start) begin
        m_frames++;
        if (m_frames == CDF) begin m_state = 2; m_frames = 0; end
      end
    end else if (m_state == 2 || m_state == 3) begin
      if (pp) begin
        m_ret = m_state; m_state = 4;
      end else if (bus.i_frame_start) begin
        m_score = (m_score < 65535) ? m_score + 1 : 65535;
        if (m_state == 2) begin
          if (m_frame_hit) begin
            m_lives--;
            if (m_lives == 0) m_state = 5;
            else begin m_state = 3; m_grace = GF; end
          end
        end else begin
          m_grace--;
          if (m_grace <= 0) begin m_state = 2; m_grace = 0; end
        end
      end
    end else if (m_state == 4) begin
      if (pp) m_state = m_ret;
    end
    m_frame_hit = bus.i_frame_start ? ph : (m_frame_hit || ph);
    m_sprev = bus.i_start_btn;
    m_pprev = bus.i_pause_btn;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_start_btn = 0; bus.i_pause_btn = 0; bus.i_frame_start = 0;
    bus.i_pixel_valid = 0; bus.i_is_obstacle = 0;
    bus.i_screen_x = '0; bus.i_screen_y = '0;
  endtask

  task automatic frame_pulse();
    bus.i_frame_start = 1; tick();
    bus.i_frame_start = 0; tick();
  endtask

  task automatic pixel(input int x, input int y, input bit obst);
    bus.i_pixel_valid = 1; bus.i_screen_x = 9'(x); bus.i_screen_y = 10'(y); bus.i_is_obstacle = obst;
    tick();
    bus.i_pixel_valid = 0; bus.i_is_obstacle = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.i_ball_x = 9'd100; bus.i_ball_y = 10'd500;
    rst = 1; tick(); tick();
    checks++; if (bus.o_engine_arst_n !== 1'b0) begin failures++; $display("FAIL rst_arst got=%0b exp=0", bus.o_engine_arst_n); end
    checks++; if (bus.o_is_pause !== 1'b1) begin failures++; $display("FAIL rst_pause got=%0b exp=1", bus.o_is_pause); end
    checks++; if (bus.o_is_lose !== 1'b0) begin failures++; $display("FAIL rst_lose got=%0b exp=0", bus.o_is_lose); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL rst_score got=%0d exp=0", bus.o_score); end
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL rst_lives got=%0d exp=3", bus.o_lives); end
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.o_state); end
    rst = 0; tick();
    checks++; if (bus.o_engine_arst_n !== 1'b1) begin failures++; $display("FAIL rst_release_arst got=%0b exp=1", bus.o_engine_arst_n); end
    bus.i_pause_btn = 1; tick(); bus.i_pause_btn = 0; tick();
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL idle_pause_ignored got=%0d exp=0", bus.o_state); end
  endtask

  task automatic test_countdown();
    bus.i_start_btn = 1; tick();
    checks++; if (bus.o_state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", bus.o_state); end
    checks++; if (bus.o_engine_arst_n !== 1'b0) begin failures++; $display("FAIL start_arst_low got=%0b exp=0", bus.o_engine_arst_n); end
    bus.i_start_btn = 0; tick();
    checks++; if (bus.o_engine_arst_n !== 1'b1) begin failures++; $display("FAIL start_arst_high got=%0b exp=1", bus.o_engine_arst_n); end
    bus.i_start_btn = 1; tick();
    checks++; if (bus.o_engine_arst_n !== 1'b1) begin failures++; $display("FAIL cd_start_ignored_arst got=%0b exp=1", bus.o_engine_arst_n); end
    bus.i_start_btn = 0; bus.i_pause_btn = 1; tick(); bus.i_pause_btn = 0; tick();
    checks++; if (bus.o_state !== 3'd1) begin failures++; $display("FAIL cd_pause_ignored got=%0d exp=1", bus.o_state); end
    repeat (CDF - 1) frame_pulse();
    checks++; if (bus.o_state !== 3'd1) begin failures++; $display("FAIL cd_before_last got=%0d exp=1", bus.o_state); end
    frame_pulse();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL cd_run_state got=%0d exp=2", bus.o_state); end
    checks++; if (bus.o_is_pause !== 1'b0) begin failures++; $display("FAIL cd_run_pause got=%0b exp=0", bus.o_is_pause); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL cd_run_score got=%0d exp=0", bus.o_score); end
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL cd_run_lives got=%0d exp=3", bus.o_lives); end
  endtask

  task automatic test_hit_grace();
    pixel(130, 500, 1); pixel(100, 530, 1); pixel(99, 510, 1); pixel(110, 510, 0);
    frame_pulse();
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL outside_box_lives got=%0d exp=3", bus.o_lives); end
    checks++; if (bus.o_score !== 16'd1) begin failures++; $display("FAIL outside_box_score got=%0d exp=1", bus.o_score); end
    pixel(110, 510, 1);
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL hit_before_frame got=%0d exp=3", bus.o_lives); end
    frame_pulse();
    checks++; if (bus.o_lives !== 2'd2) begin failures++; $display("FAIL hit1_lives got=%0d exp=2", bus.o_lives); end
    checks++; if (bus.o_state !== 3'd3) begin failures++; $display("FAIL hit1_state got=%0d exp=3", bus.o_state); end
    repeat (GF - 1) begin pixel(110, 510, 1); frame_pulse(); end
    checks++; if (bus.o_state !== 3'd3) begin failures++; $display("FAIL grace_hold_state got=%0d exp=3", bus.o_state); end
    checks++; if (bus.o_lives !== 2'd2) begin failures++; $display("FAIL grace_hold_lives got=%0d exp=2", bus.o_lives); end
    checks++; if (bus.o_score !== 16'd61) begin failures++; $display("FAIL grace_score got=%0d exp=61", bus.o_score); end
    pixel(110, 510, 1); frame_pulse();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL grace_end_state got=%0d exp=2", bus.o_state); end
    checks++; if (bus.o_lives !== 2'd2) begin failures++; $display("FAIL grace_end_lives got=%0d exp=2", bus.o_lives); end
    bus.i_start_btn = 1; tick(); bus.i_start_btn = 0; tick();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL run_start_ignored got=%0d exp=2", bus.o_state); end
    pixel(129, 529, 1); frame_pulse();
    checks++; if (bus.o_lives !== 2'd1) begin failures++; $display("FAIL corner_hit_lives got=%0d exp=1", bus.o_lives); end
    checks++; if (bus.o_score !== 16'd63) begin failures++; $display("FAIL corner_hit_score got=%0d exp=63", bus.o_score); end
    repeat (10) frame_pulse();
    bus.i_pause_btn = 1; tick();
    checks++; if (bus.o_state !== 3'd4) begin failures++; $display("FAIL hit_pause_state got=%0d exp=4", bus.o_state); end
    bus.i_pause_btn = 0; tick();
    repeat (5) begin pixel(110, 510, 1); frame_pulse(); end
    checks++; if (bus.o_score !== 16'd73) begin failures++; $display("FAIL paused_score got=%0d exp=73", bus.o_score); end
    bus.i_pause_btn = 1; tick();
    checks++; if (bus.o_state !== 3'd3) begin failures++; $display("FAIL unpause_to_hit got=%0d exp=3", bus.o_state); end
    bus.i_pause_btn = 0; tick();
    repeat (49) frame_pulse();
    checks++; if (bus.o_state !== 3'd3) begin failures++; $display("FAIL held_grace_state got=%0d exp=3", bus.o_state); end
    frame_pulse();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL held_grace_end got=%0d exp=2", bus.o_state); end
    checks++; if (bus.o_score !== 16'd123) begin failures++; $display("FAIL held_grace_score got=%0d exp=123", bus.o_score); end
    checks++; if (bus.o_lives !== 2'd1) begin failures++; $display("FAIL held_grace_lives got=%0d exp=1", bus.o_lives); end
  endtask

  task automatic test_lose_restart();
    pixel(100, 500, 1); frame_pulse();
    checks++; if (bus.o_state !== 3'd5) begin failures++; $display("FAIL lose_state got=%0d exp=5", bus.o_state); end
    checks++; if (bus.o_lives !== 2'd0) begin failures++; $display("FAIL lose_lives got=%0d exp=0", bus.o_lives); end
    checks++; if (bus.o_is_lose !== 1'b1) begin failures++; $display("FAIL lose_flag got=%0b exp=1", bus.o_is_lose); end
    checks++; if (bus.o_is_pause !== 1'b1) begin failures++; $display("FAIL lose_pause got=%0b exp=1", bus.o_is_pause); end
    repeat (3) begin pixel(110, 510, 1); frame_pulse(); end
    bus.i_pause_btn = 1; tick(); bus.i_pause_btn = 0; tick();
    checks++; if (bus.o_score !== 16'd124) begin failures++; $display("FAIL lose_score_frozen got=%0d exp=124", bus.o_score); end
    checks++; if (bus.o_state !== 3'd5) begin failures++; $display("FAIL lose_pause_ignored got=%0d exp=5", bus.o_state); end
    bus.i_start_btn = 1; tick();
    checks++; if (bus.o_state !== 3'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", bus.o_state); end
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL restart_lives got=%0d exp=3", bus.o_lives); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", bus.o_score); end
    checks++; if (bus.o_engine_arst_n !== 1'b0) begin failures++; $display("FAIL restart_arst got=%0b exp=0", bus.o_engine_arst_n); end
    checks++; if (bus.o_is_lose !== 1'b0) begin failures++; $display("FAIL restart_lose got=%0b exp=0", bus.o_is_lose); end
    bus.i_start_btn = 0; tick();
    checks++; if (bus.o_engine_arst_n !== 1'b1) begin failures++; $display("FAIL restart_arst_high got=%0b exp=1", bus.o_engine_arst_n); end
  endtask

  task automatic test_pause_frame();
    repeat (CDF) frame_pulse();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL pf_run got=%0d exp=2", bus.o_state); end
    pixel(110, 510, 1);
    bus.i_pause_btn = 1; bus.i_frame_start = 1; tick();
    checks++; if (bus.o_state !== 3'd4) begin failures++; $display("FAIL pf_state got=%0d exp=4", bus.o_state); end
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL pf_lives got=%0d exp=3", bus.o_lives); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL pf_score got=%0d exp=0", bus.o_score); end
    bus.i_pause_btn = 0; bus.i_frame_start = 0; tick();
    bus.i_start_btn = 1; tick(); bus.i_start_btn = 0; tick();
    repeat (3) frame_pulse();
    checks++; if (bus.o_state !== 3'd4) begin failures++; $display("FAIL pf_hold_state got=%0d exp=4", bus.o_state); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL pf_hold_score got=%0d exp=0", bus.o_score); end
    bus.i_pause_btn = 1; tick();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL pf_resume got=%0d exp=2", bus.o_state); end
    bus.i_pause_btn = 0; tick();
    frame_pulse();
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL pf_discarded_lives got=%0d exp=3", bus.o_lives); end
    checks++; if (bus.o_score !== 16'd1) begin failures++; $display("FAIL pf_resume_score got=%0d exp=1", bus.o_score); end
  endtask

  task automatic test_random();
    bit exp_pause, exp_lose;
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        bus.i_ball_x = 9'($urandom_range(0, 511));
        bus.i_ball_y = 10'($urandom_range(0, 1023));
      end
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 19) == 0) bus.i_start_btn = ~bus.i_start_btn;
      if ($urandom_range(0, 39) == 0) bus.i_pause_btn = ~bus.i_pause_btn;
      bus.i_frame_start = ($urandom_range(0, 2) == 0);
      bus.i_pixel_valid = 1'($urandom_range(0, 1));
      bus.i_screen_x = bus.i_ball_x + 9'($urandom_range(0, 40)) - 9'd5;
      bus.i_screen_y = bus.i_ball_y + 10'($urandom_range(0, 40)) - 10'd5;
      bus.i_is_obstacle = ($urandom_range(0, 29) == 0);
      tick();
      exp_pause = !(m_state == 2 || m_state == 3);
      exp_lose  = (m_state == 5);
      checks++; if (bus.o_state !== 3'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", c, bus.o_state, m_state); end
      checks++; if (bus.o_lives !== 2'(m_lives)) begin failures++; $display("FAIL rnd_lives cyc=%0d got=%0d exp=%0d", c, bus.o_lives, m_lives); end
      checks++; if (bus.o_score !== 16'(m_score)) begin failures++; $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", c, bus.o_score, m_score); end
      checks++; if (bus.o_engine_arst_n !== m_arst) begin failures++; $display("FAIL rnd_arst cyc=%0d got=%0b exp=%0b", c, bus.o_engine_arst_n, m_arst); end
      checks++; if (bus.o_is_pause !== exp_pause) begin failures++; $display("FAIL rnd_pause cyc=%0d got=%0b exp=%0b", c, bus.o_is_pause, exp_pause); end
      checks++; if (bus.o_is_lose !== exp_lose) begin failures++; $display("FAIL rnd_lose cyc=%0d got=%0b exp=%0b", c, bus.o_is_lose, exp_lose); end
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    bus.i_ball_x = 9'd100; bus.i_ball_y = 10'd500;
    rst = 1; tick(); rst = 0; tick();
    bus.i_start_btn = 1; tick();
    bus.i_start_btn = 0; bus.i_frame_start = 1;
    repeat (CDF) tick();
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL sat_run got=%0d exp=2", bus.o_state); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL sat_start_score got=%0d exp=0", bus.o_score); end
    repeat (65534) tick();
    checks++; if (bus.o_score !== 16'd65534) begin failures++; $display("FAIL sat_65534 got=%0d exp=65534", bus.o_score); end
    tick();
    checks++; if (bus.o_score !== 16'hFFFF) begin failures++; $display("FAIL sat_65535 got=%0d exp=65535", bus.o_score); end
    repeat (5) tick();
    checks++; if (bus.o_score !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0d exp=65535", bus.o_score); end
    checks++; if (bus.o_state !== 3'd2) begin failures++; $display("FAIL sat_state got=%0d exp=2", bus.o_state); end
    bus.i_frame_start = 0; bus.i_pixel_valid = 1; bus.i_is_obstacle = 1;
    bus.i_screen_x = 9'd110; bus.i_screen_y = 10'd510; bus.i_pause_btn = 1;
    rst = 1; tick();
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", bus.o_state); end
    checks++; if (bus.o_score !== 16'd0) begin failures++; $display("FAIL midrst_score got=%0d exp=0", bus.o_score); end
    checks++; if (bus.o_lives !== 2'd3) begin failures++; $display("FAIL midrst_lives got=%0d exp=3", bus.o_lives); end
    checks++; if (bus.o_engine_arst_n !== 1'b0) begin failures++; $display("FAIL midrst_arst got=%0b exp=0", bus.o_engine_arst_n); end
    checks++; if (bus.o_is_pause !== 1'b1) begin failures++; $display("FAIL midrst_pause got=%0b exp=1", bus.o_is_pause); end
    checks++; if (bus.o_is_lose !== 1'b0) begin failures++; $display("FAIL midrst_lose got=%0b exp=0", bus.o_is_lose); end
    idle_inputs(); rst = 0; tick();
    checks++; if (bus.o_engine_arst_n !== 1'b1) begin failures++; $display("FAIL midrst_release got=%0b exp=1", bus.o_engine_arst_n); end
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL midrst_idle got=%0d exp=0", bus.o_state); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hit_grace();
    test_lose_restart();
    test_pause_frame();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/second_game_controller.md
SECOND_GAME_CONTROLLER -- requirements
Module: second_game_controller

Interface
REQ-001 Parameter PLAYER_SIZE, default 30: side of the square ball box in pixels.
REQ-002 Parameter LIVES, default 3: lives at game start, range 1-3.
REQ-003 Parameter COUNTDOWN_FRAMES, default 180: frames held paused before play.
REQ-004 Parameter GRACE_FRAMES, default 60: invulnerable frames after a hit.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port i_start_btn, input, 1: start button level, synchronous to clk.
REQ-008 Port i_pause_btn, input, 1: pause button level, synchronous to clk.
REQ-009 Port i_frame_start, input, 1: one-cycle pulse at the start of each frame.
REQ-010 Port i_pixel_valid, input, 1: i_screen_x/y is a visible pixel this cycle.
REQ-011 Port i_screen_x, input, 9: scan x within the game field.
REQ-012 Port i_screen_y, input, 10: scan y within the game field.
REQ-013 Port i_is_obstacle, input, 1: engine obstacle flag for the current pixel.
REQ-014 Port i_ball_x, input, 9 / i_ball_y, input, 10: ball box top-left corner from the engine.
REQ-015 Port o_engine_arst_n, output, 1: active-low reset to the game engine.
REQ-016 Port o_is_pause, output, 1: freezes the engine.
REQ-017 Port o_is_lose, output, 1: game over.
REQ-018 Port o_score, output, 16: frames survived.
REQ-019 Port o_lives, output, 2: remaining lives.
REQ-020 Port o_state, output, 3: state code (IDLE=0, COUNTDOWN=1, RUN=2, HIT=3, PAUSED=4, LOSE=5).

Function
REQ-021 A button press SHALL be its rising edge: current level 1, previous registered level 0. One press per edge.
REQ-022 A pixel hit SHALL be i_pixel_valid & i_is_obstacle & (ball_x <= x <= ball_x+PLAYER_SIZE-1) & (ball_y <= y <= ball_y+PLAYER_SIZE-1). Compare in 11 bits so the box sum cannot overflow.
REQ-023 A sticky flag hit_acc SHALL set on any pixel hit.
REQ-024 hit_acc SHALL clear on every i_frame_start. A pixel hit in that same cycle belongs to the new frame and is kept.
REQ-025 Frame evaluation SHALL occur on i_frame_start and SHALL use hit_acc as it was before that cycle.
REQ-026 IDLE: start press -> COUNTDOWN; o_engine_arst_n low for exactly that 1 cycle; lives=LIVES; score=0.
REQ-027 COUNTDOWN: count i_frame_start pulses; after COUNTDOWN_FRAMES pulses -> RUN.
REQ-028 RUN at frame evaluation: score +1, saturating at 0xFFFF.
REQ-029 RUN at frame evaluation with hit_acc=1: lives -1. If the result is 0 -> LOSE, otherwise -> HIT with grace counter = GRACE_FRAMES.
REQ-030 HIT: score +1 per frame and grace counter -1 per frame; hit_acc is ignored; -> RUN when the counter reaches 0.
REQ-031 RUN/HIT: pause press -> PAUSED; the return state and grace counter are held.
REQ-032 PAUSED: pause press -> the saved state; frames are not counted; hit_acc is discarded at each frame start.
REQ-033 A pause press coinciding with i_frame_start SHALL take precedence: no score or lives update, and the frame's hit_acc is discarded.
REQ-034 LOSE: o_is_lose=1; score and lives frozen; start press -> COUNTDOWN with the same actions as REQ-026.
REQ-035 A start press in COUNTDOWN, RUN, HIT or PAUSED SHALL be ignored. A pause press in IDLE, COUNTDOWN or LOSE SHALL be ignored.
REQ-036 o_is_pause SHALL be 1 in IDLE, COUNTDOWN, PAUSED and LOSE, and 0 in RUN and HIT.
REQ-037 All outputs SHALL be registered; every state change takes effect one cycle after its triggering input.

Reset
REQ-038 While rst=1: state IDLE, o_engine_arst_n=0, o_is_pause=1, o_is_lose=0, o_score=0, o_lives=LIVES, all counters and hit_acc cleared, button history = 0.
REQ-039 rst asserted in any state, mid-frame included, SHALL override all other inputs in that cycle.
REQ-040 o_engine_arst_n SHALL go to 1 on the first cycle after rst deasserts.

Verification
REQ-041 Reset, then start press, then 180 frame pulses -> o_state=2, o_is_pause=0, o_score=0, o_lives=3; o_engine_arst_n pulses low exactly 1 cycle after the press.
REQ-042 RUN, ball (100,500), obstacle pixel at (110,510) in one frame -> next frame start: o_lives=2, o_state=3; obstacle in the next 60 frames -> no lives loss; then o_state=2.
REQ-043 Obstacle pixel at (130,500) with ball_x=100 (just outside the box) -> no hit. Pixel at (129,529) -> hit.
REQ-044 Three hits separated by grace periods -> o_lives=0, o_state=5, o_is_lose=1, o_score frozen; start press -> COUNTDOWN, o_lives=3, o_score=0.
REQ-045 In RUN, pause press on the same cycle as i_frame_start with hit_acc=1 -> o_state=4, lives and score unchanged; second pause press -> o_state=2.
REQ-046 Score preloaded by 65535 frames in RUN -> stays 0xFFFF on further frames; rst=1 mid-frame -> all REQ-038 values on the next cycle.
